// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator: carry-save accumulator that feeds a WIDTH-bit final adder.
// Each accepted beat performs one 3:2 compression, so no carry chain is needed per beat.
// At packet end the redundant pair {out_a, out_b} and out_cin (always 0) are registered.
// Optional feature macro: CSA_ACC_SUB_EN adds the in_sub port for per-beat subtraction.
module csa_stream_accumulator #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
`ifdef CSA_ACC_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_cin,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc_s;
  logic [WIDTH-1:0] acc_c;
  logic [CNT_W-1:0] cnt;

  logic             beat;
  logic             sub_bit;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] base_s;
  logic [WIDTH-1:0] base_c;
  logic [CNT_W-1:0] base_cnt;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] maj;
  logic [WIDTH-1:0] c_next;
  logic [CNT_W-1:0] cnt_next;

`ifdef CSA_ACC_SUB_EN
  assign sub_bit = in_sub;
`else
  assign sub_bit = 1'b0;
`endif

  // A new beat is taken whenever the output register is free or being emptied now.
  assign in_ready = !out_valid || out_ready;
  assign beat     = in_valid && in_ready;
  assign out_cin  = 1'b0;

  // One 3:2 compression per beat; subtraction inverts the operand and puts
  // the +1 into the otherwise-unused carry LSB.
  always_comb begin
    base_s   = (state == IDLE) ? '0 : acc_s;
    base_c   = (state == IDLE) ? '0 : acc_c;
    base_cnt = (state == IDLE) ? '0 : cnt;
    x        = in_data ^ {WIDTH{sub_bit}};
    s_next   = base_s ^ base_c ^ x;
    maj      = (base_s & base_c) | (base_s & x) | (base_c & x);
    c_next   = {maj[WIDTH-2:0], sub_bit};
    cnt_next = (base_cnt == {CNT_W{1'b1}}) ? base_cnt : base_cnt + 1'b1;
  end

  // Accumulator and packet FSM: hold a partial packet, clear on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc_s <= '0;
      acc_c <= '0;
      cnt   <= '0;
    end else if (beat) begin
      if (in_last) begin
        state <= IDLE;
        acc_s <= '0;
        acc_c <= '0;
        cnt   <= '0;
      end else begin
        state <= ACCUM;
        acc_s <= s_next;
        acc_c <= c_next;
        cnt   <= cnt_next;
      end
    end
  end

  // Output register: loads on a last beat, otherwise drains on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_count <= '0;
    end else if (beat && in_last) begin
      out_valid <= 1'b1;
      out_a     <= s_next;
      out_b     <= c_next;
      out_count <= cnt_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed bench for csa_stream_accumulator: table-driven packets plus
// hand-written backpressure, saturation, subtraction and reset sequences.
module tb_csa_stream_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
`ifdef CSA_ACC_SUB_EN
  logic        in_sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_cin;
  logic [3:0]  out_count;

  int n_vec;
  int n_bad;

  csa_stream_accumulator #(.WIDTH(32), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
`ifdef CSA_ACC_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_cin   (out_cin),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fsum();
    return out_a + out_b + {31'd0, out_cin};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Present one beat at the falling edge and let it be taken at the rising edge.
  task automatic send(input logic [31:0] d, input logic last, input logic sub);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
`ifdef CSA_ACC_SUB_EN
    in_sub   = sub;
`else
    if (sub) $display("note: subtract beat skipped in add-only build");
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
`ifdef CSA_ACC_SUB_EN
    in_sub   = 1'b0;
`endif
  endtask

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [31:0] exp_sum;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[11];

  initial begin
    n_vec = 0;
    n_bad = 0;
    vecs[0]  = '{32'h0000_0005, 1'b1, 32'h0000_0005, 4'd1};
    vecs[1]  = '{32'hFFFF_FFFF, 1'b0, 32'h0,         4'd0};
    vecs[2]  = '{32'h0000_0001, 1'b0, 32'h0,         4'd0};
    vecs[3]  = '{32'h0000_0002, 1'b1, 32'h0000_0002, 4'd3};
    vecs[4]  = '{32'h8000_0000, 1'b0, 32'h0,         4'd0};
    vecs[5]  = '{32'h8000_0000, 1'b1, 32'h0000_0000, 4'd2};
    vecs[6]  = '{32'h1234_5678, 1'b0, 32'h0,         4'd0};
    vecs[7]  = '{32'h1111_1111, 1'b1, 32'h2345_6789, 4'd2};
    vecs[8]  = '{32'hAAAA_AAAA, 1'b0, 32'h0,         4'd0};
    vecs[9]  = '{32'h5555_5555, 1'b0, 32'h0,         4'd0};
    vecs[10] = '{32'h0000_0001, 1'b1, 32'h0000_0000, 4'd3};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
`ifdef CSA_ACC_SUB_EN
    in_sub    = 1'b0;
`endif
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_a",     out_a, 32'd0);
    check("reset out_b",     out_b, 32'd0);
    check("reset out_count", {28'd0, out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: out_valid follows the last flag because out_ready is held high.
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].data, vecs[i].last, 1'b0);
      check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].last});
      if (vecs[i].last) begin
        check($sformatf("vec%0d sum", i),   fsum(), vecs[i].exp_sum);
        check($sformatf("vec%0d count", i), {28'd0, out_count}, {28'd0, vecs[i].exp_cnt});
        check($sformatf("vec%0d cin", i),   {31'd0, out_cin}, 32'd0);
      end
    end
    idle_in();
    @(posedge clk); #1;

    // Backpressure: packet {7} held for 4 clocks, next last beat waiting.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd7;
    in_last   = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    in_data = 32'd9;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp%0d in_ready", k),  {31'd0, in_ready}, 32'd0);
      check($sformatf("bp%0d out_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp%0d sum", k),       fsum(), 32'd7);
      check($sformatf("bp%0d count", k),     {28'd0, out_count}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("no bubble out_valid", {31'd0, out_valid}, 32'd1);
    check("no bubble sum",       fsum(), 32'd9);
    idle_in();
    @(posedge clk); #1;
    check("drain out_valid", {31'd0, out_valid}, 32'd0);

`ifdef CSA_ACC_SUB_EN
    send(32'd10, 1'b0, 1'b0);
    send(32'd3,  1'b1, 1'b1);
    check("sub 10-3", fsum(), 32'd7);
    send(32'd0,  1'b0, 1'b0);
    send(32'd1,  1'b1, 1'b1);
    check("sub 0-1", fsum(), 32'hFFFF_FFFF);
    idle_in();
`endif

    // Saturation: 20 beats of 1 with a 4-bit counter.
    for (int k = 0; k < 20; k++) send(32'd1, (k == 19), 1'b0);
    check("sat sum",   fsum(), 32'd20);
    check("sat count", {28'd0, out_count}, 32'd15);
    idle_in();

    // Reset mid-packet discards the partial sum.
    send(32'h100, 1'b0, 1'b0);
    send(32'h200, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h7, 1'b1, 1'b0);
    check("post-rst out_valid", {31'd0, out_valid}, 32'd1);
    check("post-rst sum",       fsum(), 32'h7);
    check("post-rst count",     {28'd0, out_count}, 32'd1);
    idle_in();
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
